// File: rtl/ip_tx_pkg.sv
// Shared types and constants for the IP TX arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a. Holds the AXIS widths, user-field layout and FSM encoding.
package ip_tx_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = 8;
    localparam int unsigned USER_W = 56;

    // User field layout, MSB first: {16 len, 3 flag, 8 type, 13 offset, 16 ID}
    localparam int unsigned USER_ID_LSB   = 0;
    localparam int unsigned USER_OFF_LSB  = 16;
    localparam int unsigned USER_TYPE_LSB = 29;
    localparam int unsigned USER_FLAG_LSB = 37;
    localparam int unsigned USER_LEN_LSB  = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [USER_W-1:0] user;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

endpackage

// File: rtl/ip_tx_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not win last time wins.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: i_req0/i_req1 requests, i_last previous winner, o_winner pick, o_valid any request.
module rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_winner,
    output logic o_valid
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_winner = ~i_last;
        end else begin
            o_winner = i_req1;
        end
    end

endmodule

// File: rtl/ip_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the IP TX input between UDP (port 0) and ICMP (port 1).
// Latency: one registered stage from granted input beat to m_axis_ip.
// Backpressure: none on the stream; req/gnt handshake, i_tx_busy blocks new grants only.
// Ports: sX_req/o_sX_gnt handshake, sX_axis_* sources, m_axis_ip_* muxed output,
//        o_active_src current/last winner, o_timeout and o_ungranted_err single-cycle pulses.
module ip_tx_arbiter
    import ip_tx_pkg::*;
#(
    parameter int unsigned P_GAP_CYCLES    = 4,
    parameter int unsigned P_GRANT_TIMEOUT = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tx_busy,
    input  logic              s0_req,
    output logic              o_s0_gnt,
    input  logic [DATA_W-1:0] s0_axis_data,
    input  logic [USER_W-1:0] s0_axis_user,
    input  logic [KEEP_W-1:0] s0_axis_keep,
    input  logic              s0_axis_last,
    input  logic              s0_axis_valid,
    input  logic              s1_req,
    output logic              o_s1_gnt,
    input  logic [DATA_W-1:0] s1_axis_data,
    input  logic [USER_W-1:0] s1_axis_user,
    input  logic [KEEP_W-1:0] s1_axis_keep,
    input  logic              s1_axis_last,
    input  logic              s1_axis_valid,
    output logic [DATA_W-1:0] m_axis_ip_data,
    output logic [USER_W-1:0] m_axis_ip_user,
    output logic [KEEP_W-1:0] m_axis_ip_keep,
    output logic              m_axis_ip_last,
    output logic              m_axis_ip_valid,
    output logic              o_active_src,
    output logic              o_timeout,
    output logic              o_ungranted_err
);

    localparam logic [15:0] TMO_LAST = 16'(P_GRANT_TIMEOUT - 1);
    localparam logic [7:0]  GAP_LAST = 8'(P_GAP_CYCLES - 1);
    // With no gap configured a finished grant returns straight to arbitration.
    localparam state_t      ST_AFTER = (P_GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        active_src_q, active_src_d;
    logic        r_last_q, r_last_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        timeout_q, timeout_d;
    logic        uerr_q, uerr_d;
    logic        valid_q, valid_d;
    beat_t       beat_q, beat_d;

    logic        arb_winner;
    logic        arb_valid;
    logic        in_pkt;
    logic        sel_valid;
    logic        fwd;
    logic        eop;
    logic        tmo_hit;
    beat_t       sel_beat;

    rr_arb2 u_rr_arb2 (
        .i_req0   (s0_req),
        .i_req1   (s1_req),
        .i_last   (r_last_q),
        .o_winner (arb_winner),
        .o_valid  (arb_valid)
    );

    always_comb begin
        // active_src_q always names the granted port while in GRANT/XFER
        sel_valid = active_src_q ? s1_axis_valid : s0_axis_valid;
        sel_beat  = active_src_q
                  ? '{data: s1_axis_data, user: s1_axis_user, keep: s1_axis_keep, last: s1_axis_last}
                  : '{data: s0_axis_data, user: s0_axis_user, keep: s0_axis_keep, last: s0_axis_last};
        in_pkt    = (state_q == ST_GRANT) || (state_q == ST_XFER);
        fwd       = in_pkt && sel_valid;
        eop       = fwd && sel_beat.last;
        // A beat arriving on the final allowed cycle still wins over the timeout.
        tmo_hit   = (state_q == ST_GRANT) && !sel_valid && (tmo_cnt_q == TMO_LAST);

        state_d      = state_q;
        gnt_d        = gnt_q;
        active_src_d = active_src_q;
        r_last_d     = r_last_q;
        tmo_cnt_d    = tmo_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        timeout_d    = tmo_hit;
        uerr_d       = (s0_axis_valid && !gnt_q[0]) || (s1_axis_valid && !gnt_q[1]);
        valid_d      = fwd;
        beat_d       = fwd ? sel_beat : '0;

        case (state_q)
            ST_IDLE: begin
                if (!i_tx_busy && arb_valid) begin
                    state_d      = ST_GRANT;
                    gnt_d        = arb_winner ? 2'b10 : 2'b01;
                    active_src_d = arb_winner;
                    r_last_d     = arb_winner;
                    tmo_cnt_d    = '0;
                end
            end
            ST_GRANT: begin
                if (eop || tmo_hit) begin
                    state_d   = ST_AFTER;
                    gnt_d     = '0;
                    gap_cnt_d = '0;
                end else if (fwd) begin
                    state_d = ST_XFER;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            ST_XFER: begin
                if (eop) begin
                    state_d   = ST_AFTER;
                    gnt_d     = '0;
                    gap_cnt_d = '0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            active_src_q <= 1'b0;
            r_last_q     <= 1'b1;
            tmo_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            uerr_q       <= 1'b0;
            valid_q      <= 1'b0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            active_src_q <= active_src_d;
            r_last_q     <= r_last_d;
            tmo_cnt_q    <= tmo_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            timeout_q    <= timeout_d;
            uerr_q       <= uerr_d;
            valid_q      <= valid_d;
            beat_q       <= beat_d;
        end
    end

    assign o_s0_gnt        = gnt_q[0];
    assign o_s1_gnt        = gnt_q[1];
    assign o_active_src    = active_src_q;
    assign o_timeout       = timeout_q;
    assign o_ungranted_err = uerr_q;
    assign m_axis_ip_valid = valid_q;
    assign m_axis_ip_data  = beat_q.data;
    assign m_axis_ip_user  = beat_q.user;
    assign m_axis_ip_keep  = beat_q.keep;
    assign m_axis_ip_last  = beat_q.last;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
`timescale 1ns/1ps
module tb_ip_tx_arbiter;

    localparam int GAP = 4;
    localparam int TMO = 16;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_tx_busy = 1'b0;
    logic        s0_req = 1'b0, s1_req = 1'b0;
    logic        o_s0_gnt, o_s1_gnt;
    logic [63:0] s0_axis_data = '0, s1_axis_data = '0;
    logic [55:0] s0_axis_user = '0, s1_axis_user = '0;
    logic [7:0]  s0_axis_keep = '0, s1_axis_keep = '0;
    logic        s0_axis_last = 1'b0, s1_axis_last = 1'b0;
    logic        s0_axis_valid = 1'b0, s1_axis_valid = 1'b0;
    logic [63:0] m_axis_ip_data;
    logic [55:0] m_axis_ip_user;
    logic [7:0]  m_axis_ip_keep;
    logic        m_axis_ip_last, m_axis_ip_valid;
    logic        o_active_src, o_timeout, o_ungranted_err;

    ip_tx_arbiter #(.P_GAP_CYCLES(GAP), .P_GRANT_TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_tx_busy(i_tx_busy),
        .s0_req(s0_req), .o_s0_gnt(o_s0_gnt),
        .s0_axis_data(s0_axis_data), .s0_axis_user(s0_axis_user), .s0_axis_keep(s0_axis_keep),
        .s0_axis_last(s0_axis_last), .s0_axis_valid(s0_axis_valid),
        .s1_req(s1_req), .o_s1_gnt(o_s1_gnt),
        .s1_axis_data(s1_axis_data), .s1_axis_user(s1_axis_user), .s1_axis_keep(s1_axis_keep),
        .s1_axis_last(s1_axis_last), .s1_axis_valid(s1_axis_valid),
        .m_axis_ip_data(m_axis_ip_data), .m_axis_ip_user(m_axis_ip_user),
        .m_axis_ip_keep(m_axis_ip_keep), .m_axis_ip_last(m_axis_ip_last),
        .m_axis_ip_valid(m_axis_ip_valid),
        .o_active_src(o_active_src), .o_timeout(o_timeout), .o_ungranted_err(o_ungranted_err)
    );

    always #5 i_clk = ~i_clk;

    // Expected output beat, stamped with the cycle it was driven on the input.
    typedef struct {
        logic [63:0] data;
        logic [55:0] user;
        logic [7:0]  keep;
        logic        last;
        int          stamp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   ill_now = 1'b0;
    bit   ill_prev = 1'b0;
    int   tmo_cnt = 0;
    int   uerr_cnt = 0;
    int   model_last = 1;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drv(input int p, input logic v, input logic [63:0] d, input logic [55:0] u,
                       input logic [7:0] k, input logic l);
        if (p == 0) begin
            s0_axis_valid = v; s0_axis_data = d; s0_axis_user = u; s0_axis_keep = k; s0_axis_last = l;
        end else begin
            s1_axis_valid = v; s1_axis_data = d; s1_axis_user = u; s1_axis_keep = k; s1_axis_last = l;
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? o_s0_gnt : o_s1_gnt;
    endfunction

    task automatic wait_gnt(input int p, input int max, output int lat);
        lat = 0;
        while (!gnt_of(p) && lat < max) begin
            step();
            lat++;
        end
        if (!gnt_of(p)) chk("gnt_wait_expired", 64'(p), 64'hFF);
    endtask

    task automatic wait_any(input int max, output int p, output int lat);
        lat = 0;
        while (!(o_s0_gnt || o_s1_gnt) && lat < max) begin
            step();
            lat++;
        end
        if (!(o_s0_gnt || o_s1_gnt)) chk("any_gnt_wait_expired", 64'(lat), 64'(max + 1));
        p = o_s1_gnt ? 1 : 0;
    endtask

    task automatic wait_idle();
        repeat (GAP + 1) step();
    endtask

    // Granted source: random idle cycles between beats, random payload;
    // the first ill_beats beats are shadowed by an illegal valid on the other port.
    task automatic send(input int p, input int len, input int ill_beats, input bit busy_mid,
                        input logic [7:0] klast);
        logic [63:0] d;
        logic [55:0] u;
        logic [7:0]  k;
        logic        l;
        int          gaps;
        exp_t        e;
        for (int b = 0; b < len; b++) begin
            gaps = $urandom_range(0, 2);
            repeat (gaps) step();
            d = {$urandom(), $urandom()};
            u = 56'({$urandom(), $urandom()});
            l = (b == len - 1);
            k = l ? ((klast != 8'h00) ? klast : 8'($urandom_range(1, 255))) : 8'hFF;
            drv(p, 1'b1, d, u, k, l);
            if (b < ill_beats) begin
                drv(1 - p, 1'b1, ~d, ~u, 8'hFF, 1'b0);
                ill_now = 1'b1;
            end
            if (busy_mid && b == 0) i_tx_busy = 1'b1;
            e.data = d; e.user = u; e.keep = k; e.last = l; e.stamp = cyc;
            exp_q.push_back(e);
            step();
            drv(p, 1'b0, '0, '0, '0, 1'b0);
            drv(1 - p, 1'b0, '0, '0, '0, 1'b0);
            ill_now = 1'b0;
        end
        chk("gnt_drop_after_last", 64'(gnt_of(p)), 64'd0);
        i_tx_busy = 1'b0;
    endtask

    always @(negedge i_clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].stamp < cyc - 1) begin
                chk("beat_lost_stamp", 64'(exp_q[0].stamp), 64'(cyc - 1));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].stamp == cyc - 1) begin
                chk("out_valid", 64'(m_axis_ip_valid), 64'd1);
                chk("out_data", m_axis_ip_data, exp_q[0].data);
                chk("out_user", 64'(m_axis_ip_user), 64'(exp_q[0].user));
                chk("out_keep", 64'(m_axis_ip_keep), 64'(exp_q[0].keep));
                chk("out_last", 64'(m_axis_ip_last), 64'(exp_q[0].last));
                void'(exp_q.pop_front());
            end else begin
                chk("idle_valid", 64'(m_axis_ip_valid), 64'd0);
                chk("idle_keep", 64'(m_axis_ip_keep), 64'd0);
                chk("idle_last", 64'(m_axis_ip_last), 64'd0);
            end
            chk("ungranted_err", 64'(o_ungranted_err), 64'(ill_prev));
            ill_prev = ill_now;
            if (o_timeout) tmo_cnt++;
            if (o_ungranted_err) uerr_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, p, exp_w, pat, uerr_base;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_valid", 64'(m_axis_ip_valid), 64'd0);
        chk("rst_data", m_axis_ip_data, 64'd0);
        chk("rst_user", 64'(m_axis_ip_user), 64'd0);
        chk("rst_keep", 64'(m_axis_ip_keep), 64'd0);
        chk("rst_gnt0", 64'(o_s0_gnt), 64'd0);
        chk("rst_gnt1", 64'(o_s1_gnt), 64'd0);
        chk("rst_src", 64'(o_active_src), 64'd0);
        chk("rst_tmo", 64'(o_timeout), 64'd0);
        chk("rst_uerr", 64'(o_ungranted_err), 64'd0);
        i_rst = 1'b0;
        mon_en = 1'b1;
        step();

        // Single requester, 3 beats ending in keep F0, then gap before re-grant
        s0_req = 1'b1;
        wait_gnt(0, 8, lat);
        chk("t1_gnt_lat", 64'(lat), 64'd1);
        chk("t1_src", 64'(o_active_src), 64'd0);
        chk("t1_other_gnt", 64'(o_s1_gnt), 64'd0);
        model_last = 0;
        s0_req = 1'b0;
        send(0, 3, 0, 1'b0, 8'hF0);
        s0_req = 1'b1;
        wait_gnt(0, 20, lat);
        chk("t1_gap_lat", 64'(lat), 64'(GAP + 1));
        model_last = 0;
        s0_req = 1'b0;
        send(0, 1, 0, 1'b0, 8'h00);
        wait_idle();

        // Both requesting continuously: strict alternation
        s0_req = 1'b1;
        s1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_w = 1 - model_last;
            wait_any(20, p, lat);
            chk("t2_winner", 64'(p), 64'(exp_w));
            chk("t2_src", 64'(o_active_src), 64'(exp_w));
            chk("t2_single_gnt", 64'(o_s0_gnt & o_s1_gnt), 64'd0);
            if (i > 0) chk("t2_gap_lat", 64'(lat), 64'(GAP + 1));
            model_last = p;
            send(p, $urandom_range(1, 5), 0, 1'b0, 8'h00);
        end
        s0_req = 1'b0;
        s1_req = 1'b0;
        wait_idle();

        // Random request patterns from idle
        for (int r = 0; r < 10; r++) begin
            pat = $urandom_range(1, 3);
            s0_req = pat[0];
            s1_req = pat[1];
            exp_w = (pat == 3) ? 1 - model_last : ((pat == 2) ? 1 : 0);
            wait_any(8, p, lat);
            chk("rnd_winner", 64'(p), 64'(exp_w));
            chk("rnd_lat", 64'(lat), 64'd1);
            s0_req = 1'b0;
            s1_req = 1'b0;
            model_last = p;
            send(p, $urandom_range(1, 6), 0, 1'b0, 8'h00);
            wait_idle();
        end

        // Busy holds off a pending request; busy mid-packet is ignored
        i_tx_busy = 1'b1;
        s1_req = 1'b1;
        repeat (10) begin
            step();
            chk("t3_no_gnt_busy", 64'(o_s0_gnt | o_s1_gnt), 64'd0);
        end
        i_tx_busy = 1'b0;
        wait_gnt(1, 8, lat);
        chk("t3_gnt_lat", 64'(lat), 64'd1);
        model_last = 1;
        s1_req = 1'b0;
        send(1, 4, 0, 1'b1, 8'h00);
        wait_idle();

        // Grant timeout with a pending request from the other port
        s0_req = 1'b1;
        wait_gnt(0, 8, lat);
        model_last = 0;
        s0_req = 1'b0;
        s1_req = 1'b1;
        lat = 0;
        while (!o_timeout && lat < 40) begin
            step();
            lat++;
        end
        chk("t4_tmo_lat", 64'(lat), 64'(TMO));
        chk("t4_gnt_drop", 64'(o_s0_gnt), 64'd0);
        step();
        chk("t4_tmo_pulse", 64'(o_timeout), 64'd0);
        wait_gnt(1, 20, lat);
        chk("t4_regrant_lat", 64'(lat), 64'(GAP));
        model_last = 1;
        s1_req = 1'b0;
        send(1, 2, 0, 1'b0, 8'h00);
        wait_idle();

        // Ungranted valid from port 1 while port 0 transfers
        uerr_base = uerr_cnt;
        s0_req = 1'b1;
        wait_gnt(0, 8, lat);
        model_last = 0;
        s0_req = 1'b0;
        send(0, 4, 2, 1'b0, 8'h00);
        wait_idle();
        chk("t5_uerr_count", 64'(uerr_cnt - uerr_base), 64'd2);

        // Asynchronous reset in the middle of a 5-beat packet
        s0_req = 1'b1;
        wait_gnt(0, 8, lat);
        s0_req = 1'b0;
        for (int b = 0; b < 3; b++) begin
            exp_t e;
            e.data = {$urandom(), $urandom()};
            e.user = 56'({$urandom(), $urandom()});
            e.keep = 8'hFF; e.last = 1'b0; e.stamp = cyc;
            drv(0, 1'b1, e.data, e.user, e.keep, e.last);
            exp_q.push_back(e);
            step();
        end
        chk("t6_pre_valid", 64'(m_axis_ip_valid), 64'd1);
        #2;
        mon_en = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(m_axis_ip_valid), 64'd0);
        chk("t6_rst_data", m_axis_ip_data, 64'd0);
        chk("t6_rst_gnt", 64'(o_s0_gnt), 64'd0);
        exp_q.delete();
        drv(0, 1'b0, '0, '0, '0, 1'b0);
        repeat (2) step();
        i_rst = 1'b0;
        ill_prev = 1'b0;
        mon_en = 1'b1;
        model_last = 1;
        step();
        s0_req = 1'b1;
        s1_req = 1'b1;
        wait_any(8, p, lat);
        chk("t6_winner", 64'(p), 64'd0);
        chk("t6_lat", 64'(lat), 64'd1);
        s0_req = 1'b0;
        s1_req = 1'b0;
        send(0, 2, 0, 1'b0, 8'h00);
        wait_idle();

        repeat (4) step();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("final_tmo_count", 64'(tmo_cnt), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
